// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cacheline to 4x64-bit memory burst adaptor (option: CACHELINE_ADAPTOR_EARLY_RESP_EN)
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((1 << OFF_W) - 1));
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [LINE_W-1:0]  line_buf;   // write data to send, or read beats gathered so far
    logic [LINE_W-1:0]  line_q;     // last fully completed read line
    logic [LINE_W-1:0]  rd_line;    // line_buf with the incoming beat dropped into slot cnt
    logic [BURST_W-1:0] wr_beat;
    logic               last_beat;

    assign last_beat = ((state == S_RD) || (state == S_WR)) && resp_i && (cnt == LAST_CNT);

    // Beat slot selection for both directions, indexed by the beat counter
    always_comb begin
        rd_line = line_buf;
        wr_beat = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (cnt == CNT_W'(b)) begin
                rd_line[b*BURST_W +: BURST_W] = burst_i;
                wr_beat = line_buf[b*BURST_W +: BURST_W];
            end
        end
    end

    // Transaction FSM, beat counter and data/address capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            line_buf  <= '0;
            line_q    <= '0;
            address_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // write takes priority over a simultaneous read
                    if (write_i) begin
                        line_buf  <= line_i;
                        address_o <= address_i & ALIGN_MASK;
                        cnt       <= '0;
                        state     <= S_WR;
                    end else if (read_i) begin
                        address_o <= address_i & ALIGN_MASK;
                        cnt       <= '0;
                        state     <= S_RD;
                    end
                end
                S_RD: begin
                    if (resp_i) begin
                        line_buf <= rd_line;
                        cnt      <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            // line_o only changes once the whole line has arrived
                            line_q <= rd_line;
                            state  <= S_DONE;
                        end
                    end
                end
                S_WR: begin
                    if (resp_i) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            state <= S_DONE;
                        end
                    end
                end
                default: begin
                    // held requests are ignored here so they cannot retrigger
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign read_o  = (state == S_RD);
    assign write_o = (state == S_WR);
    assign burst_o = write_o ? wr_beat : '0;

`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
    // Respond alongside the final beat and bypass that beat straight onto line_o
    assign resp_o = last_beat;
    assign line_o = (last_beat && (state == S_RD)) ? rd_line : line_q;
`else
    // Registered response: one cycle in DONE, line already settled in line_q
    assign resp_o = (state == S_DONE);
    assign line_o = line_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - scoreboard bench for cacheline_adaptor
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    int ntests = 0;
    int nfail  = 0;
    logic [255:0] sb_line[$];
    logic [63:0]  sb_beat[$];
    logic [255:0] prev_line;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read line; pat bit i says whether memory returns a beat in cycle i.
    // started=1 means the DUT already entered RD_BURST on a held read_i.
    task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                           input logic [15:0] pat, input int plen, input bit started);
        int beat;
        beat = 0;
        sb_line.push_back(line);
        address_i = addr;
        read_i    = 1'b1;
        if (!started) @(negedge clk);
        for (int i = 0; i < plen; i++) begin
            chk("rd_read_o", read_o, 1);
            chk("rd_write_o", write_o, 0);
            chk("rd_addr", address_o, addr & 32'hFFFF_FFE0);
            resp_i  = pat[i];
            burst_i = pat[i] ? line[beat*64 +: 64] : {$urandom(), $urandom()};
            #1;
            if (pat[i] && beat == 3 && EARLY) begin
                chk("rd_early_resp", resp_o, 1);
                chk("rd_early_line", line_o, sb_line.pop_front());
            end else begin
                chk("rd_resp_low", resp_o, 0);
                chk("rd_line_hold", line_o, prev_line);
            end
            if (pat[i]) beat++;
            @(negedge clk);
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        chk("rd_read_o_drop", read_o, 0);
        if (!EARLY) begin
            chk("rd_resp", resp_o, 1);
            chk("rd_line", line_o, sb_line.pop_front());
        end else begin
            chk("rd_dead_resp", resp_o, 0);
            chk("rd_line_after", line_o, line);
        end
        prev_line = line;
        @(negedge clk);
        chk("rd_resp_pulse", resp_o, 0);
        chk("rd_idle_read_o", read_o, 0);
    endtask

    // Write line with beat handshake pattern; rd_too also raises read_i and keeps it held.
    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input logic [15:0] pat, input int plen, input bit rd_too);
        for (int b = 0; b < 4; b++) sb_beat.push_back(line[b*64 +: 64]);
        line_i    = line;
        address_i = addr;
        write_i   = 1'b1;
        read_i    = rd_too;
        @(negedge clk);
        for (int i = 0; i < plen; i++) begin
            chk("wr_write_o", write_o, 1);
            chk("wr_read_o", read_o, 0);
            chk("wr_addr", address_o, addr & 32'hFFFF_FFE0);
            chk("wr_burst", burst_o, sb_beat[0]);
            resp_i = pat[i];
            #1;
            if (pat[i] && sb_beat.size() == 1 && EARLY) chk("wr_early_resp", resp_o, 1);
            else chk("wr_resp_low", resp_o, 0);
            if (pat[i]) void'(sb_beat.pop_front());
            @(negedge clk);
        end
        resp_i  = 1'b0;
        write_i = 1'b0;
        chk("wr_write_o_drop", write_o, 0);
        chk("wr_done_read_o", read_o, 0);
        chk("wr_resp", resp_o, EARLY ? 1'b0 : 1'b1);
        chk("wr_line_o_untouched", line_o, prev_line);
        @(negedge clk);
        chk("wr_resp_pulse", resp_o, 0);
        chk("wr_idle_read_o", read_o, 0);
        if (rd_too) begin
            @(negedge clk);
            chk("held_read_starts", read_o, 1);
        end
    endtask

    initial begin
        logic [255:0] rl;
        logic [255:0] l1;
        rst_n     = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        prev_line = '0;
        repeat (2) @(negedge clk);
        chk("rst_read_o", read_o, 0);
        chk("rst_write_o", write_o, 0);
        chk("rst_resp_o", resp_o, 0);
        chk("rst_address_o", address_o, 0);
        chk("rst_burst_o", burst_o, 0);
        chk("rst_line_o", line_o, 0);
        rst_n  = 1'b1;
        @(negedge clk);
        resp_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_resp_i_resp_o", resp_o, 0);
        chk("idle_resp_i_read_o", read_o, 0);
        chk("idle_resp_i_write_o", write_o, 0);
        resp_i = 1'b0;

        l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        do_read(32'h0000_1234, l1, 16'h000F, 4, 1'b0);

        do_write(32'h8000_0040, {64'hD, 64'hC, 64'hB, 64'hA}, 16'h000F, 4, 1'b0);

        rl = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        do_read(32'h1357_9BDF, rl, 16'b1011001, 7, 1'b0);

        rl = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        do_write(32'h0000_0FFF, rl, 16'b11011, 5, 1'b1);
        rl = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        do_read(32'h0000_0FFF, rl, 16'h000F, 4, 1'b1);

        // abort a read after two beats
        address_i = 32'h0000_1234;
        read_i    = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom(), $urandom()};
            @(negedge clk);
        end
        chk("partial_line_hold", line_o, prev_line);
        resp_i = 1'b0;
        read_i = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("abort_read_o", read_o, 0);
        chk("abort_line_o", line_o, 0);
        chk("abort_resp_o", resp_o, 0);
        prev_line = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_read(32'h0000_1234, l1, 16'h000F, 4, 1'b0);

        chk("sb_lines_drained", sb_line.size(), 0);
        chk("sb_beats_drained", sb_beat.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Memory-side counterpart of the cache data arrays: converts one 256-bit cacheline transfer into a 4-beat, 64-bit burst on the physical memory interface.
- On a write, serialises a line out to memory. On a read, deserialises beats back into a line.
- Sits between the cache controller (line side) and main memory / arbiter (burst side).
- One transaction at a time; the cache holds its request until resp_o.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, memory beat width in bits. LINE_W must be an integer multiple of it.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- line_i  in  LINE_W  line to write, from the cache.
- line_o  out  LINE_W  assembled read line, to the cache.
- address_i  in  ADDR_W  line address from the cache.
- read_i  in  1  line read request, level, held until resp_o.
- write_i  in  1  line write request, level, held until resp_o.
- resp_o  out  1  transaction complete, one-cycle pulse.
- burst_i  in  BURST_W  read beat from memory.
- burst_o  out  BURST_W  write beat to memory.
- address_o  out  ADDR_W  line-aligned burst address.
- read_o  out  1  burst read request.
- write_o  out  1  burst write request.
- resp_i  in  1  memory beat handshake; one beat per cycle it is high.

Behaviour:
- BEATS = LINE_W/BURST_W (4). The beat counter is clog2(BEATS) bits, cleared on entry to any burst state.
- Reset (asynchronous, rst_n=0):
  - state=IDLE, beat counter=0.
  - resp_o, read_o, write_o = 0.
  - address_o, burst_o, line_o = 0.
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - write_i=1: latch line_i into the shift buffer, latch address_i with the low clog2(LINE_W/8) bits zeroed, go to WR_BURST.
  - Otherwise read_i=1: latch the address the same way, go to RD_BURST.
  - write_i and read_i both high: write wins and the read is ignored.
- RD_BURST:
  - read_o=1 and address_o=latched address.
  - On each cycle with resp_i=1, burst_i is stored to line bits [cnt*BURST_W +: BURST_W] and cnt increments.
  - On the beat with cnt=BEATS-1, go to DONE. read_o drops to 0 in DONE.
- WR_BURST:
  - write_o=1 and burst_o = beat[cnt] of the latched line, beat 0 at LSBs.
  - cnt advances on each resp_i=1. After beat BEATS-1 is accepted, go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle, then IDLE.
  - read_i/write_i are ignored in DONE, so a held request does not retrigger.
  - A new request is accepted in the IDLE cycle after DONE.
- line_o holds the last completed read line until the next read completes. It is not modified by writes or by partial reads.
- resp_i outside RD_BURST/WR_BURST is ignored.
- Non-contiguous resp_i (gaps) is legal; the burst stalls, holding burst_o and cnt.
- Latency with no gaps:
  - read_i sampled at edge T gives read_o from T+1, beats at T+1..T+4, resp_o during T+5.
  - Total is 5 cycles plus memory wait cycles.
- Reset mid-burst aborts immediately: read_o/write_o drop with reset asserted, and line_o clears to 0. After reset the cache must reissue the request.

Optional Feature:
- CACHELINE_ADAPTOR_EARLY_RESP_EN defined:
  - resp_o asserts combinationally in the same cycle as the final resp_i beat.
  - On a read, line_o forwards burst_i into the top beat slot in that cycle (write-through bypass), so line_o is valid with resp_o.
  - The DONE state becomes a one-cycle dead state with resp_o=0.
  - Read latency drops by one cycle.
- Undefined: behaviour as specified above, with resp_o registered in DONE.

Test Plan:
- Read, no gaps: address_i=0x0000_1234, read_i=1; return beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220, read_o high 4 cycles, one resp_o pulse, line_o=0x44..44_33..33_22..22_11..11.
- Write: line_i = {64'hD,64'hC,64'hB,64'hA}, address_i=0x8000_0040, write_i=1; resp_i high 4 cycles -> burst_o sequence A,B,C,D, write_o deasserts after the 4th beat, one resp_o pulse.
- Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, cnt frozen on gaps, resp_o once, read_o high for all 7 cycles.
- Simultaneous read_i=1 and write_i=1 in IDLE -> write burst performed, read_o never asserted; read_i held after resp_o starts a read only after the IDLE cycle.
- Reset mid-read after 2 beats: rst_n=0 -> read_o=0, line_o=0, resp_o=0 immediately; rst_n=1 with request reissued -> full 4-beat read completes correctly.
- With CACHELINE_ADAPTOR_EARLY_RESP_EN: same read as the first scenario -> resp_o high in the cycle of the 4th beat, line_o equals the full line in that same cycle.
